majority_vote_ctrl: RTL

MAJORITY_VOTE_CTRL -- requirements
Module: majority_vote_ctrl

---
 rtl/majority_vote_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/majority_vote_ctrl.sv
// rtl/majority_vote_ctrl.sv - five-voter majority round controller with timeout
// One round: collect up to five ballots, decide by popcount >= 3, hold result until acked.
module majority_vote_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] vote_req,
    input  logic [4:0] vote_val,
    output logic [4:0] vote_ack,
    input  logic       result_ack,
    output logic       result,
    output logic       result_valid,
    output logic       timed_out,
    output logic [4:0] voted_mask,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [4:0]  voted_mask_q, voted_mask_d;
    logic [4:0]  ballot_q, ballot_d;
    logic [4:0]  vote_ack_q, vote_ack_d;
    logic [15:0] cnt_q, cnt_d;
    logic        result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic        timed_out_q, timed_out_d;
    logic [4:0]  accept;
    logic [2:0]  ones;

    always_comb begin
        state_d        = state_q;
        voted_mask_d   = voted_mask_q;
        ballot_d       = ballot_q;
        vote_ack_d     = 5'b0;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        timed_out_d    = timed_out_q;
        accept         = 5'b0;
        ones           = 3'd0;
        for (int i = 0; i < 5; i++) begin
            ones = ones + {2'b00, ballot_q[i]};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    voted_mask_d = 5'b0;
                    ballot_d     = 5'b0;
                    timed_out_d  = 1'b0;
                    cnt_d        = 16'd0;
                    state_d      = COLLECT;
                end
            end
            COLLECT: begin
                // Only first ballot per voter counts; later requests are neither stored nor acked.
                accept       = vote_req & ~voted_mask_q;
                ballot_d     = ballot_q | (accept & vote_val);
                voted_mask_d = voted_mask_q | accept;
                vote_ack_d   = accept;
                cnt_d        = cnt_q + 16'd1;
                if ((voted_mask_d == 5'b11111) || (cnt_q == CNT_LAST)) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                result_d       = (ones >= 3'd3);
                result_valid_d = 1'b1;
                timed_out_d    = (voted_mask_q != 5'b11111);
                state_d        = DONE;
            end
            DONE: begin
                if (result_ack) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            voted_mask_q   <= 5'b0;
            ballot_q       <= 5'b0;
            vote_ack_q     <= 5'b0;
            cnt_q          <= 16'd0;
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
            timed_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            voted_mask_q   <= voted_mask_d;
            ballot_q       <= ballot_d;
            vote_ack_q     <= vote_ack_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timed_out_q    <= timed_out_d;
        end
    end

    assign vote_ack     = vote_ack_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timed_out    = timed_out_q;
    assign voted_mask   = voted_mask_q;
    assign busy         = (state_q != IDLE);

endmodule
